// File: rtl/lut_sched_pkg.sv
// Shared sizing, FSM state type and address-gather helper for the LUT layer scheduler.
package lut_sched_pkg;

   localparam int N_IN     = 32;
   localparam int IN_W     = 2;
   localparam int FAN_IN   = 3;
   localparam int N_NEU    = 16;
   localparam int OUT_W    = 2;

   localparam int AW       = FAN_IN * IN_W;
   localparam int NEU_W    = $clog2(N_NEU);
   localparam int SEL_W    = $clog2(N_IN);
   localparam int TT_DEPTH = N_NEU << AW;
   localparam int TT_AW    = NEU_W + AW;
   localparam int CN_N     = N_NEU * FAN_IN;
   localparam int CN_AW    = $clog2(CN_N);
   // One extra bit so out-of-range feature indices can be presented and rejected.
   localparam int CN_DW    = $clog2(N_IN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_e;

   // Concatenate the selected features; slot 0 lands in the LSBs of the address.
   function automatic logic [AW-1:0] build_addr(input logic [N_IN*IN_W-1:0]     vec,
                                                input logic [FAN_IN*SEL_W-1:0] sel);
      logic [AW-1:0] a;
      a = '0;
      for (int s = 0; s < FAN_IN; s++) begin
         a[s*IN_W +: IN_W] = vec[int'(sel[s*SEL_W +: SEL_W])*IN_W +: IN_W];
      end
      return a;
   endfunction

endpackage

// File: rtl/lut_tt_ram.sv
// Truth-table storage: one write port, one registered read port, no reset on contents.
module lut_tt_ram
   import lut_sched_pkg::*;
#(
   parameter int DEPTH  = TT_DEPTH,
   parameter int WIDTH  = OUT_W,
   parameter int ADDR_W = TT_AW
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   (* ram_style = "distributed" *) logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write and synchronous read; contents intentionally survive reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_scheduler.sv
// Evaluates the neurons of one LogicNets layer in turn through a shared, runtime-loadable truth table.
module lut_layer_scheduler
   import lut_sched_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_IN*IN_W-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N_NEU*OUT_W-1:0] out_data,
   input  logic                   tt_we,
   input  logic [TT_AW-1:0]       tt_addr,
   input  logic [OUT_W-1:0]       tt_wdata,
   input  logic                   cn_we,
   input  logic [CN_AW-1:0]       cn_addr,
   input  logic [CN_DW-1:0]       cn_wdata,
   output logic                   busy,
   output logic                   cfg_err
);

   state_e                  state_q, state_d;
   logic [NEU_W-1:0]        cnt_q, cnt_d;
   logic                    issue_q, issue_d;
   logic                    cfg_err_q, cfg_err_d;

   logic                    vld_p1_q;
   logic [NEU_W-1:0]        idx_p1_q;
   logic                    last_p2_q;
   logic [N_NEU*OUT_W-1:0]  out_q;

   logic [N_IN*IN_W-1:0]    vec_q;
   logic [SEL_W-1:0]        cn_q [CN_N];

   logic                    idle;
   logic                    accept;
   logic                    cn_bad;
   logic                    tt_wr;
   logic                    cn_wr;
   logic [FAN_IN*SEL_W-1:0] sel;
   logic [AW-1:0]           addr;
   logic [OUT_W-1:0]        tt_rdata;

   assign idle   = (state_q == IDLE);
   assign accept = idle && in_valid;

   // Config writes are legal only while no vector is in flight; bad feature or slot indices are dropped.
   always_comb begin
      cn_bad    = (int'(cn_wdata) >= N_IN) || (int'(cn_addr) >= CN_N);
      tt_wr     = tt_we && idle;
      cn_wr     = cn_we && idle && !cn_bad;
      cfg_err_d = ((tt_we || cn_we) && !idle) || (cn_we && idle && cn_bad);
   end

   // Gather the connectivity entries of the neuron being issued and form its table address.
   always_comb begin
      logic [CN_AW-1:0] ci;
      sel = '0;
      ci  = '0;
      for (int s = 0; s < FAN_IN; s++) begin
         ci = CN_AW'(int'(cnt_q) * FAN_IN + s);
         sel[s*SEL_W +: SEL_W] = cn_q[ci];
      end
      addr = build_addr(vec_q, sel);
   end

   lut_tt_ram #(
      .DEPTH  (TT_DEPTH),
      .WIDTH  (OUT_W),
      .ADDR_W (TT_AW)
   ) u_tt_ram (
      .clk_i   (clk),
      .we_i    (tt_wr),
      .waddr_i (tt_addr),
      .wdata_i (tt_wdata),
      .re_i    (issue_q),
      .raddr_i ({cnt_q, addr}),
      .rdata_o (tt_rdata)
   );

   // Next-state logic: one neuron issued per EVAL cycle, DONE once the last result has landed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      issue_d = issue_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = EVAL;
               cnt_d   = '0;
               issue_d = 1'b1;
            end
         end
         EVAL: begin
            if (issue_q) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == NEU_W'(N_NEU - 1)) begin
                  issue_d = 1'b0;
               end
            end
            if (last_p2_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            issue_d = 1'b0;
         end
      endcase
   end

   // FSM, issue counter and error-pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         issue_q   <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         issue_q   <= issue_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Stage p0 -> p1: table read issued; p1 -> p2: result written into its output slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q  <= 1'b0;
         last_p2_q <= 1'b0;
         out_q     <= '0;
      end else begin
         vld_p1_q  <= issue_q;
         last_p2_q <= vld_p1_q && (idx_p1_q == NEU_W'(N_NEU - 1));
         if (vld_p1_q) begin
            out_q[int'(idx_p1_q)*OUT_W +: OUT_W] <= tt_rdata;
         end
      end
   end

   // Neuron index travelling alongside the pending table read.
   always_ff @(posedge clk) begin
      if (issue_q) begin
         idx_p1_q <= cnt_q;
      end
   end

   // Input vector capture on the accepting edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         vec_q <= in_data;
      end
   end

   // Connectivity table; contents survive reset.
   always_ff @(posedge clk) begin
      if (cn_wr) begin
         cn_q[cn_addr] <= cn_wdata[SEL_W-1:0];
      end
   end

   assign in_ready  = idle;
   assign busy      = !idle;
   assign out_valid = (state_q == DONE);
   assign out_data  = out_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Directed bench for lut_layer_scheduler with hand-computed layer results.
module tb_lut_layer_scheduler;
   import lut_sched_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [N_IN*IN_W-1:0]   in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [N_NEU*OUT_W-1:0] out_data;
   logic                   tt_we;
   logic [TT_AW-1:0]       tt_addr;
   logic [OUT_W-1:0]       tt_wdata;
   logic                   cn_we;
   logic [CN_AW-1:0]       cn_addr;
   logic [CN_DW-1:0]       cn_wdata;
   logic                   busy;
   logic                   cfg_err;

   int n_cmp = 0;
   int n_bad = 0;

   lut_layer_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .tt_we     (tt_we),
      .tt_addr   (tt_addr),
      .tt_wdata  (tt_wdata),
      .cn_we     (cn_we),
      .cn_addr   (cn_addr),
      .cn_wdata  (cn_wdata),
      .busy      (busy),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic submit(input logic [N_IN*IN_W-1:0] v);
      in_data  = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
   endtask

   // v1: feature f = f mod 4, except feat9 = 0 and feat31 = 2.
   // Table rule: tt[n][a] = (a[1:0] + n) mod 4, with tt[0][6'b100001] = 2.
   // Connectivity: neuron 0 = {5,9,31}; neuron n>0 slot s = (n + 7s) mod 32.
   localparam logic [31:0] EXP_V1 = 32'h8884888A;
   localparam logic [31:0] EXP_V2 = 32'h93939393;
   localparam logic [31:0] EXP_V3 = 32'hE4E4E4EC;

   initial begin
      logic [N_IN*IN_W-1:0] v1;
      logic [31:0]          hold;
      int                   lat;
      int                   n0sel [3];

      n0sel     = '{5, 9, 31};
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tt_we     = 1'b0;
      tt_addr   = '0;
      tt_wdata  = '0;
      cn_we     = 1'b0;
      cn_addr   = '0;
      cn_wdata  = '0;

      for (int f = 0; f < N_IN; f++) v1[f*IN_W +: IN_W] = IN_W'(f & 3);
      v1[9*IN_W +: IN_W]  = 2'b00;
      v1[31*IN_W +: IN_W] = 2'b10;

      repeat (2) tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);
      rst_n = 1'b1;
      tick();

      // Load truth tables and connectivity.
      tt_we = 1'b1;
      for (int n = 0; n < N_NEU; n++) begin
         for (int a = 0; a < (1 << AW); a++) begin
            tt_addr  = TT_AW'((n << AW) + a);
            tt_wdata = OUT_W'((a + n) & 3);
            tick();
         end
      end
      tt_addr  = TT_AW'(6'b100001);
      tt_wdata = 2'b10;
      tick();
      tt_we = 1'b0;
      cn_we = 1'b1;
      for (int n = 0; n < N_NEU; n++) begin
         for (int s = 0; s < FAN_IN; s++) begin
            cn_addr  = CN_AW'(n * FAN_IN + s);
            cn_wdata = (n == 0) ? CN_DW'(n0sel[s]) : CN_DW'((n + 7 * s) % N_IN);
            tick();
         end
      end
      cn_we = 1'b0;
      chk("legal_cfg_no_err", 32'(cfg_err), 32'd0);
      tick();

      // Mapping and latency.
      submit(v1);
      chk("eval_in_ready", 32'(in_ready), 32'd0);
      chk("eval_busy", 32'(busy), 32'd1);
      wait_done(lat);
      chk("latency_v1", 32'(lat), 32'd18);
      chk("map_neuron0", 32'(out_data[1:0]), 32'd2);
      chk("result_v1", out_data, EXP_V1);

      // Backpressure with in_valid toggling in DONE.
      hold = out_data;
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = '1;
         tick();
         chk("bp_out_data", out_data, hold);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      release_out("bp");
      chk("bp_not_busy", 32'(busy), 32'd0);
      tick();
      chk("bp_no_accept", 32'(busy), 32'd0);

      // All-ones vector.
      submit('1);
      wait_done(lat);
      chk("latency_v2", 32'(lat), 32'd18);
      chk("result_v2", out_data, EXP_V2);
      release_out("v2");

      // Table write during EVAL must be rejected.
      submit(v1);
      repeat (3) tick();
      tt_we    = 1'b1;
      tt_addr  = TT_AW'((5 << AW) + 49);
      tt_wdata = 2'b01;
      tick();
      chk("eval_wr_err", 32'(cfg_err), 32'd1);
      tt_we = 1'b0;
      tick();
      chk("eval_wr_err_end", 32'(cfg_err), 32'd0);
      wait_done(lat);
      chk("eval_wr_result", out_data, EXP_V1);
      release_out("evwr");

      // Out-of-range feature index in IDLE.
      cn_we    = 1'b1;
      cn_addr  = '0;
      cn_wdata = CN_DW'(32);
      tick();
      chk("badidx_err", 32'(cfg_err), 32'd1);
      cn_we = 1'b0;
      tick();
      chk("badidx_err_end", 32'(cfg_err), 32'd0);
      submit(v1);
      wait_done(lat);
      chk("badidx_kept", out_data, EXP_V1);
      release_out("badidx");

      // Reset mid-EVAL, then resubmit.
      submit(v1);
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_out_data", out_data, 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      chk("mrst_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      submit(v1);
      wait_done(lat);
      chk("mrst_latency", 32'(lat), 32'd18);
      chk("mrst_result", out_data, EXP_V1);
      release_out("mrst");

      // Config write in the accepting cycle is seen by that vector.
      in_data  = '0;
      in_valid = 1'b1;
      tt_we    = 1'b1;
      tt_addr  = TT_AW'((1 << AW) + 0);
      tt_wdata = 2'b11;
      tick();
      in_valid = 1'b0;
      tt_we    = 1'b0;
      chk("same_cyc_no_err", 32'(cfg_err), 32'd0);
      wait_done(lat);
      chk("same_cyc_result", out_data, EXP_V3);
      release_out("v3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
